fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the decode/execute datapath.
- Owns the PC and issues word requests to a multi-cycle instruction memory over a req/ack handshake.
- Buffers returned instructions in a small FIFO and presents them to decode with valid/ready.
- Handles branch redirects (flush) and stops fetching after a HLT opcode (4'hF).

---
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack handshake,
// buffers them in a small FIFO for decode and handles redirects and HLT.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc,
    output logic [15:0] id_pc_plus2,
    output logic [15:0] pc,
    output logic        hlt
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [0:0] S_FETCH  = 1'b0;
    localparam logic [0:0] S_HALTED = 1'b1;

    logic [0:0]       state;
    logic             run;
    logic             pending;
    logic             discard;
    logic             hlt_q;
    logic [15:0]      pc_q;
    logic [15:0]      req_addr;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [15:0]      buf_instr [BUF_DEPTH];
    logic [15:0]      buf_pc    [BUF_DEPTH];

    logic             req;
    logic             acc;
    logic             enq;
    logic             deq;
    logic             head_valid;
    logic [15:0]      head_instr;
    logic [15:0]      head_pc;

    always_comb begin
        // run holds requests off for one cycle after reset is released
        req        = run & (pending | ((state == S_FETCH) && (count < FULL)));
        acc        = req & imem_ack;
        enq        = acc & ~discard & ~redirect;
        head_valid = (count != '0);
        head_instr = buf_instr[rd_ptr];
        head_pc    = buf_pc[rd_ptr];
        deq        = head_valid & id_ready & ~redirect;
    end

    assign imem_req    = req;
    assign imem_addr   = pending ? req_addr : pc_q;
    assign id_valid    = head_valid;
    assign id_instr    = head_valid ? head_instr : '0;
    assign id_pc       = head_valid ? head_pc : '0;
    assign id_pc_plus2 = id_pc + 16'd2;
    assign pc          = pc_q;
    assign hlt         = hlt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            run      <= 1'b0;
            pending  <= 1'b0;
            discard  <= 1'b0;
            hlt_q    <= 1'b0;
            pc_q     <= RESET_PC;
            req_addr <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            run <= 1'b1;

            if (acc)
                pending <= 1'b0;
            else if (req)
                pending <= 1'b1;

            if (req && !pending)
                req_addr <= pc_q;

            // A request already on the bus when redirected must still complete
            // at its old address; also covers a request raised this very cycle.
            if (acc)
                discard <= 1'b0;
            else if (redirect && req)
                discard <= 1'b1;

            if (redirect) begin
                pc_q   <= redirect_pc;
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                state  <= S_FETCH;
            end else begin
                if (enq) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    pc_q   <= pc_q + 16'd2;
                    if (imem_data[15:12] == OP_HLT)
                        state <= S_HALTED;
                end
                if (deq)
                    rd_ptr <= rd_ptr + 1'b1;
                if (enq && !deq)
                    count <= count + 1'b1;
                else if (!enq && deq)
                    count <= count - 1'b1;
            end

            if (deq && (head_instr[15:12] == OP_HLT))
                hlt_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            buf_instr[wr_ptr] <= imem_data;
            buf_pc[wr_ptr]    <= pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake latency, backpressure, redirect,
// HLT handling, PC wrap and reset during an outstanding fetch.
module tb_fetch_unit;

    logic        clk         = 1'b0;
    logic        rst         = 1'b1;
    logic        imem_ack    = 1'b0;
    logic [15:0] imem_data   = 16'h0000;
    logic        redirect    = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        id_ready    = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic [15:0] id_pc_plus2;
    logic [15:0] pc;
    logic        hlt;

    logic        imem_req2;
    logic [15:0] imem_addr2;
    logic        imem_ack2;
    logic [15:0] imem_data2;
    logic        id_valid2;
    logic [15:0] id_instr2;
    logic [15:0] id_pc2;
    logic [15:0] id_pc_plus2_2;
    logic [15:0] pc2;
    logic        hlt2;

    int          n_cmp    = 0;
    int          n_bad    = 0;
    int unsigned lat      = 0;
    int unsigned mem_cnt  = 0;
    logic        stale    = 1'b0;
    logic [15:0] hlt_addr = 16'hFFFF;

    fetch_unit #(.RESET_PC(16'h0000), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .redirect(redirect),
        .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus2(id_pc_plus2),
        .pc(pc), .hlt(hlt)
    );

    // Second instance starting at the top of the address space, zero-wait memory.
    fetch_unit #(.RESET_PC(16'hFFFE), .BUF_DEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack2), .imem_data(imem_data2), .redirect(1'b0),
        .redirect_pc(16'h0000), .id_valid(id_valid2), .id_ready(1'b1),
        .id_instr(id_instr2), .id_pc(id_pc2), .id_pc_plus2(id_pc_plus2_2),
        .pc(pc2), .hlt(hlt2)
    );

    assign imem_ack2  = imem_req2;
    assign imem_data2 = {4'h2, imem_addr2[11:0]};

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == hlt_addr)
            return 16'hF000;
        return {4'h1, a[11:0]};
    endfunction

    // Memory responder: acks after lat wait cycles; stale forces a spurious ack.
    always @(negedge clk) begin
        if (stale) begin
            imem_ack  = 1'b1;
            imem_data = 16'hF123;
            mem_cnt   = 0;
        end else if (rst || !imem_req) begin
            imem_ack  = 1'b0;
            imem_data = 16'h0000;
            mem_cnt   = 0;
        end else begin
            imem_ack  = (mem_cnt == lat);
            imem_data = imem_ack ? mem_word(imem_addr) : 16'h0000;
            mem_cnt   = imem_ack ? 0 : mem_cnt + 1;
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // Returns in the first cycle with rst low; requests may start the next cycle.
    task automatic do_reset;
        rst      = 1'b1;
        redirect = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        lat = 0; id_ready = 1'b1; hlt_addr = 16'hFFFF;
        do_reset();
        n_cmp++;
        if ({imem_req, id_valid, hlt, pc, id_instr} !== {3'b000, 16'h0000, 16'h0000}) begin
            n_bad++;
            $display("FAIL reset_state: got req/valid/hlt/pc/instr=%b/%b/%b/%h/%h required 0/0/0/0000/0000",
                     imem_req, id_valid, hlt, pc, id_instr);
        end
        tick();
        n_cmp++;
        if ({imem_req, imem_addr, id_valid} !== {1'b1, 16'h0000, 1'b0}) begin
            n_bad++;
            $display("FAIL first_req: got req/addr/valid=%b/%h/%b required 1/0000/0", imem_req, imem_addr, id_valid);
        end
        tick();
        n_cmp++;
        if ({id_valid, id_pc, id_pc_plus2, id_instr} !== {1'b1, 16'h0000, 16'h0002, 16'h1000}) begin
            n_bad++;
            $display("FAIL first_valid: got valid/pc/pc2/instr=%b/%h/%h/%h required 1/0000/0002/1000",
                     id_valid, id_pc, id_pc_plus2, id_instr);
        end
        tick();
        n_cmp++;
        if ({id_valid, id_pc, id_instr} !== {1'b1, 16'h0002, 16'h1002}) begin
            n_bad++;
            $display("FAIL stream_2: got valid/pc/instr=%b/%h/%h required 1/0002/1002", id_valid, id_pc, id_instr);
        end
        tick();
        n_cmp++;
        if ({id_valid, id_pc, id_pc_plus2} !== {1'b1, 16'h0004, 16'h0006}) begin
            n_bad++;
            $display("FAIL stream_4: got valid/pc/pc2=%b/%h/%h required 1/0004/0006", id_valid, id_pc, id_pc_plus2);
        end
    endtask

    task automatic test_wrap;
        do_reset();
        n_cmp++;
        if ({imem_req2, pc2} !== {1'b0, 16'hFFFE}) begin
            n_bad++;
            $display("FAIL wrap_reset: got req/pc=%b/%h required 0/fffe", imem_req2, pc2);
        end
        tick();
        n_cmp++;
        if ({imem_req2, imem_addr2} !== {1'b1, 16'hFFFE}) begin
            n_bad++;
            $display("FAIL wrap_req: got req/addr=%b/%h required 1/fffe", imem_req2, imem_addr2);
        end
        tick();
        n_cmp++;
        if ({id_valid2, id_pc2, id_pc_plus2_2, id_instr2, imem_addr2} !==
            {1'b1, 16'hFFFE, 16'h0000, 16'h2FFE, 16'h0000}) begin
            n_bad++;
            $display("FAIL wrap_head: got valid/pc/pc2/instr/addr=%b/%h/%h/%h/%h required 1/fffe/0000/2ffe/0000",
                     id_valid2, id_pc2, id_pc_plus2_2, id_instr2, imem_addr2);
        end
    endtask

    task automatic test_backpressure;
        lat = 1; id_ready = 1'b0; hlt_addr = 16'hFFFF;
        do_reset();
        repeat (5) tick();
        n_cmp++;
        if ({imem_req, pc, id_valid, id_pc, id_instr} !== {1'b0, 16'h0004, 1'b1, 16'h0000, 16'h1000}) begin
            n_bad++;
            $display("FAIL full_stall: got req/pc/valid/idpc/instr=%b/%h/%b/%h/%h required 0/0004/1/0000/1000",
                     imem_req, pc, id_valid, id_pc, id_instr);
        end
        tick();
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL full_hold: got req=%b required 0", imem_req);
        end
        id_ready = 1'b1;
        tick();
        n_cmp++;
        if ({imem_req, imem_addr, id_valid, id_pc} !== {1'b1, 16'h0004, 1'b1, 16'h0002}) begin
            n_bad++;
            $display("FAIL drain_resume: got req/addr/valid/idpc=%b/%h/%b/%h required 1/0004/1/0002",
                     imem_req, imem_addr, id_valid, id_pc);
        end
        tick();
        n_cmp++;
        if ({imem_req, id_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL drain_empty: got req/valid=%b/%b required 1/0", imem_req, id_valid);
        end
        tick();
        n_cmp++;
        if ({id_valid, id_pc, id_instr} !== {1'b1, 16'h0004, 16'h1004}) begin
            n_bad++;
            $display("FAIL drain_next: got valid/pc/instr=%b/%h/%h required 1/0004/1004", id_valid, id_pc, id_instr);
        end
    endtask

    task automatic test_redirect_discard;
        bit found;
        bit leaked;
        lat = 2; id_ready = 1'b1; hlt_addr = 16'hFFFF;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (imem_req && imem_addr == 16'h0006) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL disc_wait: got no request for 0006 within 40 cycles, required one");
        end
        tick();
        redirect = 1'b1; redirect_pc = 16'h0040;
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0006}) begin
            n_bad++;
            $display("FAIL disc_redir_cycle: got req/addr=%b/%h required 1/0006", imem_req, imem_addr);
        end
        tick();
        redirect = 1'b0;
        n_cmp++;
        if ({imem_req, imem_addr, pc, id_valid} !== {1'b1, 16'h0006, 16'h0040, 1'b0}) begin
            n_bad++;
            $display("FAIL disc_hold: got req/addr/pc/valid=%b/%h/%h/%b required 1/0006/0040/0",
                     imem_req, imem_addr, pc, id_valid);
        end
        tick();
        n_cmp++;
        if ({imem_req, imem_addr, id_valid} !== {1'b1, 16'h0040, 1'b0}) begin
            n_bad++;
            $display("FAIL disc_newreq: got req/addr/valid=%b/%h/%b required 1/0040/0", imem_req, imem_addr, id_valid);
        end
        leaked = 1'b0;
        repeat (2) begin
            tick();
            if (id_valid !== 1'b0) leaked = 1'b1;
        end
        n_cmp++;
        if (leaked) begin
            n_bad++;
            $display("FAIL disc_dropped: got id_valid=1 while target in flight, required 0");
        end
        tick();
        n_cmp++;
        if ({id_valid, id_pc, id_instr} !== {1'b1, 16'h0040, 16'h1040}) begin
            n_bad++;
            $display("FAIL disc_target: got valid/pc/instr=%b/%h/%h required 1/0040/1040", id_valid, id_pc, id_instr);
        end
    endtask

    task automatic reach_hlt_head(input string name);
        bit found;
        lat = 0; id_ready = 1'b1; hlt_addr = 16'h0008;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (id_valid && id_pc == 16'h0008) begin
                found = 1'b1;
                break;
            end
        end
        id_ready = 1'b0;
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL %s_wait: got no head at 0008 within 40 cycles, required one", name);
        end
        n_cmp++;
        if ({imem_req, pc, id_instr, hlt} !== {1'b0, 16'h000A, 16'hF000, 1'b0}) begin
            n_bad++;
            $display("FAIL %s_stop: got req/pc/instr/hlt=%b/%h/%h/%b required 0/000a/f000/0",
                     name, imem_req, pc, id_instr, hlt);
        end
    endtask

    task automatic test_halt;
        reach_hlt_head("halt");
        tick();
        n_cmp++;
        if ({id_valid, hlt, imem_req} !== 3'b100) begin
            n_bad++;
            $display("FAIL halt_held: got valid/hlt/req=%b/%b/%b required 1/0/0", id_valid, hlt, imem_req);
        end
        id_ready = 1'b1;
        tick();
        n_cmp++;
        if ({hlt, id_valid, imem_req} !== 3'b100) begin
            n_bad++;
            $display("FAIL halt_set: got hlt/valid/req=%b/%b/%b required 1/0/0", hlt, id_valid, imem_req);
        end
        tick();
        n_cmp++;
        if ({hlt, imem_req} !== 2'b10) begin
            n_bad++;
            $display("FAIL halt_sticky: got hlt/req=%b/%b required 1/0", hlt, imem_req);
        end
    endtask

    task automatic test_halt_flushed;
        reach_hlt_head("hflush");
        tick();
        id_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0020;
        tick();
        redirect = 1'b0;
        n_cmp++;
        if ({hlt, id_valid, imem_req, imem_addr} !== {1'b0, 1'b0, 1'b1, 16'h0020}) begin
            n_bad++;
            $display("FAIL hflush_redir: got hlt/valid/req/addr=%b/%b/%b/%h required 0/0/1/0020",
                     hlt, id_valid, imem_req, imem_addr);
        end
        tick();
        n_cmp++;
        if ({id_valid, id_pc, id_instr, hlt} !== {1'b1, 16'h0020, 16'h1020, 1'b0}) begin
            n_bad++;
            $display("FAIL hflush_target: got valid/pc/instr/hlt=%b/%h/%h/%b required 1/0020/1020/0",
                     id_valid, id_pc, id_instr, hlt);
        end
    endtask

    task automatic test_reset_mid_fetch;
        lat = 2; id_ready = 1'b1; hlt_addr = 16'hFFFF;
        do_reset();
        tick();
        tick();
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
            n_bad++;
            $display("FAIL rstmid_pending: got req/addr=%b/%h required 1/0000", imem_req, imem_addr);
        end
        rst = 1'b1; stale = 1'b1;
        tick();
        n_cmp++;
        if ({imem_req, id_valid, hlt, pc, imem_addr, id_instr} !==
            {3'b000, 16'h0000, 16'h0000, 16'h0000}) begin
            n_bad++;
            $display("FAIL rstmid_state: got req/valid/hlt/pc/addr/instr=%b/%b/%b/%h/%h/%h required 0/0/0/0000/0000/0000",
                     imem_req, id_valid, hlt, pc, imem_addr, id_instr);
        end
        rst = 1'b0; stale = 1'b0;
        tick();
        n_cmp++;
        if ({imem_req, imem_addr, id_valid, pc} !== {1'b1, 16'h0000, 1'b0, 16'h0000}) begin
            n_bad++;
            $display("FAIL rstmid_stale: got req/addr/valid/pc=%b/%h/%b/%h required 1/0000/0/0000",
                     imem_req, imem_addr, id_valid, pc);
        end
        repeat (3) tick();
        n_cmp++;
        if ({id_valid, id_pc, id_instr, hlt} !== {1'b1, 16'h0000, 16'h1000, 1'b0}) begin
            n_bad++;
            $display("FAIL rstmid_restart: got valid/pc/instr/hlt=%b/%h/%h/%b required 1/0000/1000/0",
                     id_valid, id_pc, id_instr, hlt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_wrap();
        test_backpressure();
        test_redirect_discard();
        test_halt();
        test_halt_flushed();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
